// File: rtl/alu_exec_unit_if.sv
// Operand/op request channel and result response channel for alu_exec_unit.
// The master modport is the issuing initiator; the slave modport is the execution unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_zero;
  logic             rsp_err;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err, rsp_ovf
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage handshaked wrapper around the 32-bit ALU function set
// (AND, OR, ADD, SUB, SLT). S1 holds the captured request, S2 holds the computed
// response. Full backpressure, at most two requests in flight, completed
// responses counted in txn_count (wrapping).
// Optional macro ALU_OVF_EN: when defined, rsp_ovf reports signed overflow for
// ADD/SUB; when undefined, rsp_ovf is tied low and no overflow logic exists.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_exec_unit_if.slave   bus,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [2:0]       s1_op_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_z_reg;
  logic             s2_zero_reg;
  logic             s2_err_reg;
  logic             s2_ovf_reg;
  logic [CNT_W-1:0] txn_count_reg;

  logic             accept;
  logic             advance;
  logic             complete;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sub_ovf;
  logic [WIDTH-1:0] z_next;
  logic             err_next;
  logic             ovf_next;

  // S1 may take a new request whenever it is empty or is about to drain into S2.
  assign bus.req_ready = !s1_valid_reg || !s2_valid_reg || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;
  assign advance       = s1_valid_reg && (!s2_valid_reg || bus.rsp_ready);
  assign complete      = s2_valid_reg && bus.rsp_ready;

  assign bus.rsp_valid = s2_valid_reg;
  assign bus.rsp_z     = s2_z_reg;
  assign bus.rsp_zero  = s2_zero_reg;
  assign bus.rsp_err   = s2_err_reg;
  assign bus.rsp_ovf   = s2_ovf_reg;
  assign txn_count     = txn_count_reg;

  // ALU datapath on the S1 operands; SLT uses the subtraction sign corrected
  // by signed overflow so that extreme operands compare correctly.
  always_comb begin
    sum      = s1_a_reg + s1_b_reg;
    diff     = s1_a_reg - s1_b_reg;
    sub_ovf  = (s1_a_reg[WIDTH-1] ^ s1_b_reg[WIDTH-1]) &
               (diff[WIDTH-1] ^ s1_a_reg[WIDTH-1]);
    z_next   = '0;
    err_next = 1'b0;
    case (s1_op_reg)
      OP_AND:  z_next = s1_a_reg & s1_b_reg;
      OP_OR:   z_next = s1_a_reg | s1_b_reg;
      OP_ADD:  z_next = sum;
      OP_SUB:  z_next = diff;
      OP_SLT:  z_next = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default: err_next = 1'b1;
    endcase
  end

`ifdef ALU_OVF_EN
  logic add_ovf;

  // Signed overflow flag: ADD overflows when like-signed operands give an
  // opposite-signed sum; SUB reuses the SLT correction term.
  always_comb begin
    add_ovf  = ~(s1_a_reg[WIDTH-1] ^ s1_b_reg[WIDTH-1]) &
               (sum[WIDTH-1] ^ s1_a_reg[WIDTH-1]);
    ovf_next = 1'b0;
    if (s1_op_reg == OP_ADD) ovf_next = add_ovf;
    else if (s1_op_reg == OP_SUB) ovf_next = sub_ovf;
  end
`else
  assign ovf_next = 1'b0;
`endif

  // Stage 1: capture an accepted request, release it once it moves to S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_a_reg     <= bus.req_a;
        s1_b_reg     <= bus.req_b;
        s1_op_reg    <= bus.req_op;
      end else if (advance) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2: register the computed response; a completion and an advance on
  // the same edge reload S2 without a bubble, otherwise the response holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_z_reg     <= '0;
      s2_zero_reg  <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_ovf_reg   <= 1'b0;
    end else begin
      if (advance) begin
        s2_valid_reg <= 1'b1;
        s2_z_reg     <= z_next;
        s2_zero_reg  <= (z_next == '0);
        s2_err_reg   <= err_next;
        s2_ovf_reg   <= ovf_next;
      end else if (complete) begin
        s2_valid_reg <= 1'b0;
      end
    end
  end

  // Completed-response counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_count_reg <= '0;
    end else if (complete) begin
      txn_count_reg <= txn_count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected responses are queued when a
// request is accepted and compared in order when the unit completes them.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] z;
    logic        zero;
    logic        err;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] txn_count;
  int          vectors;
  int          miscompares;
  exp_t        sb[$];

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour written from the ALU definition, not the RTL structure.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
`ifdef ALU_OVF_EN
    longint s;
`endif
    e = '0;
    case (op)
      3'd0: e.z = a & b;
      3'd1: e.z = a | b;
      3'd2: begin
        e.z = a + b;
`ifdef ALU_OVF_EN
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
      end
      3'd6: begin
        e.z = a - b;
`ifdef ALU_OVF_EN
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
      end
      3'd7: e.z = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.z == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  // Wait (bounded) for the driven request to be taken; returns 1 ns after the accepting edge.
  task automatic wait_accept(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        sb.push_back(model(bus.req_op, bus.req_a, bus.req_b));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check({tag, "_accept"}, {63'd0, done}, 64'd1);
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    wait_accept(tag);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response that completes must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      check("rsp_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_z",    {32'd0, bus.rsp_z},    {32'd0, e.z});
        check("rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, e.zero});
        check("rsp_err",  {63'd0, bus.rsp_err},  {63'd0, e.err});
        check("rsp_ovf",  {63'd0, bus.rsp_ovf},  {63'd0, e.ovf});
      end
    end
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_txn",       {48'd0, txn_count},     64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_rsp_z",     {32'd0, bus.rsp_z},     64'd0);
    check("rst_rsp_flags", {61'd0, bus.rsp_zero, bus.rsp_err, bus.rsp_ovf}, 64'd0);
    cycles(1);

    // Back-to-back with latency check
    send("b2b_add", 3'd2, 32'd5, 32'd7);
    check("lat_add_not_yet", {63'd0, bus.rsp_valid}, 64'd0);
    send("b2b_sub", 3'd6, 32'd3, 32'd3);
    check("lat_add_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("lat_add_z",     {32'd0, bus.rsp_z},     64'd12);
    send("b2b_and", 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    check("b2b_sub_z",    {32'd0, bus.rsp_z},    64'd0);
    check("b2b_sub_zero", {63'd0, bus.rsp_zero}, 64'd1);
    cycles(1);
    check("b2b_and_z", {32'd0, bus.rsp_z}, 64'hF000F000);
    cycles(1);
    check("b2b_drained", {63'd0, bus.rsp_valid}, 64'd0);
    check("b2b_txn",     {48'd0, txn_count},     64'd3);

    // SLT corner cases and OR
    send("slt_m1_1",   3'd7, 32'hFFFFFFFF, 32'd1);
    send("slt_min_1",  3'd7, 32'h80000000, 32'd1);
    send("slt_1_min",  3'd7, 32'd1,        32'h80000000);
    send("or_0f_f0",   3'd1, 32'h0000000F, 32'h000000F0);
    cycles(3);
    check("slt_txn", {48'd0, txn_count}, 64'd7);

    // Backpressure: two accepted, third held off, output stable
    bus.rsp_ready = 1'b0;
    send("bp_a", 3'd2, 32'd1,  32'd2);
    send("bp_b", 3'd6, 32'd10, 32'd4);
    drive(3'd1, 32'h100, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
      check("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("bp_z_stable",  {32'd0, bus.rsp_z},     64'd3);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_accept("bp_c");
    cycles(4);
    check("bp_txn", {48'd0, txn_count}, 64'd10);
    check("bp_sb_empty", {32'd0, sb.size()}, 64'd0);

    // Illegal opcode
    send("illegal_4", 3'd4, 32'd9, 32'd9);
    cycles(2);
    check("illegal_txn", {48'd0, txn_count}, 64'd11);

    // Overflow cases (flag expected only when the feature is built in)
    send("ovf_add", 3'd2, 32'h7FFFFFFF, 32'd1);
    send("ovf_sub", 3'd6, 32'h80000000, 32'd1);
    cycles(3);
    check("ovf_txn", {48'd0, txn_count}, 64'd13);

    // Reset with two requests in flight
    bus.rsp_ready = 1'b0;
    send("mid_illegal", 3'd5, 32'd1, 32'd1);
    send("mid_add",     3'd2, 32'd4, 32'd4);
    check("mid_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("mid_err",   {63'd0, bus.rsp_err},   64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("mid_rst_z",     {32'd0, bus.rsp_z},     64'd0);
    check("mid_rst_flags", {61'd0, bus.rsp_zero, bus.rsp_err, bus.rsp_ovf}, 64'd0);
    check("mid_rst_txn",   {48'd0, txn_count},     64'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    check("post_rst_txn", {48'd0, txn_count}, 64'd0);
    check("final_sb_empty", {32'd0, sb.size()}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Handshaked, pipelined execution wrapper for the 32-bit ALU function set (AND, OR, ADD, SUB, SLT).
- Responder side of the ALU operand/op interface: accepts requests from an issuing initiator (bench or future datapath sequencer) and returns result, zero flag and error flag.
- Two-stage pipeline with full backpressure; counts completed transactions.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept request this cycle
- req_a  input  WIDTH  operand A (signed for SLT/overflow)
- req_b  input  WIDTH  operand B
- req_op  input  3  0=AND 1=OR 2=ADD 6=SUB 7=SLT; others illegal
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_z  output  WIDTH  result
- rsp_zero  output  1  rsp_z == 0
- rsp_err  output  1  request carried illegal op
- rsp_ovf  output  1  signed overflow (see Optional Feature)
- txn_count  output  CNT_W  completed responses, wraps

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_z=0, rsp_zero=0, rsp_err=0, rsp_ovf=0, txn_count=0; req_ready=1 once reset deasserts.
- Accept: edge with req_valid && req_ready captures a, b, op into S1.
- S2 advance: S1 moves to S2 when s1_valid && (!s2_valid || rsp_ready); S2 registers computed z, zero, err, ovf.
- Latency: request accepted at edge N -> rsp_valid high after edge N+1 when unstalled; throughput 1/cycle.
- req_ready = !s1_valid || !s2_valid || rsp_ready (combinational, no dependence on req_valid).
- Response completes on edge with rsp_valid && rsp_ready; txn_count increments by 1, wraps from 2^CNT_W-1 to 0.
- Stall: while rsp_valid && !rsp_ready, rsp_* hold stable; S1 holds; at most 2 requests in flight.
- Simultaneous complete + advance on same edge: S2 reloads from S1, rsp_valid stays 1, no bubble.
- Arithmetic: ADD/SUB modulo 2^WIDTH; SLT = 1 if signed a < signed b else 0, via subtraction with sign/overflow correction (correct for a=0x80000000, b=1).
- Illegal op (3,4,5): rsp_z=0, rsp_zero=1, rsp_err=1, rsp_ovf=0; still counted in txn_count.
- Reset mid-operation: in-flight requests discarded, no response produced.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: rsp_ovf=1 for ADD when operand signs equal and result sign differs; for SUB when operand signs differ and result sign differs from a; 0 for other ops.
- Undefined: rsp_ovf tied 0; no overflow logic synthesized; all other behaviour identical.

Test Plan:
- Reset mid-stream with 2 requests in flight -> all rsp_* and txn_count 0 immediately, no response after release.
- Back-to-back, rsp_ready=1: ADD 5+7, SUB 3-3, AND 0xF0F0F0F0&0xFF00FF00 -> 12 (zero=0), 0 (zero=1), 0xF000F000 on consecutive cycles, first 2 edges after accept, txn_count=3.
- SLT: a=0xFFFFFFFF, b=1 -> 1; a=0x80000000, b=1 -> 1; a=1, b=0x80000000 -> 0; OR 0x0F|0xF0 -> 0xFF.
- Backpressure: rsp_ready=0, 3 requests offered -> 2 accepted, req_ready=0, rsp_z stable; rsp_ready=1 -> all 3 drain in order, no loss/duplicate.
- Illegal op=4, a=9, b=9 -> rsp_z=0, rsp_zero=1, rsp_err=1, txn_count increments.
- ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> z=0x80000000, ovf=1; SUB 0x80000000-1 -> ovf=1; without macro both ovf=0.
